// File: rtl/bc_fir_pkg.sv
// rtl/bc_fir_pkg.sv - shared types and constants for the binary FIR datapath
package bc_fir_pkg;

    localparam int SAMPLE_N = 11;
    localparam int FIR_TAPS = 39;

    typedef logic [SAMPLE_N:0] sample_t;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } tap_state_e;

endpackage

// File: rtl/bc_tap_shift.sv
// rtl/bc_tap_shift.sv - DEPTH x W shift register, taps[0] newest, sync clear over enable
module bc_tap_shift #(
    parameter int W     = 12,
    parameter int DEPTH = 39
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [W-1:0]              din,
    output logic [DEPTH-1:0][W-1:0]   taps
);

    always_ff @(posedge clock) begin
        if (clear) begin
            taps <= '0;
        end else if (enable) begin
            taps <= {taps[DEPTH-2:0], din};
        end
    end

endmodule

// File: rtl/bc_fir_tapline.sv
// rtl/bc_fir_tapline.sv - sample delay line with warm-up, backpressure and zero flush feeding the FIR
module bc_fir_tapline
    import bc_fir_pkg::*;
#(
    parameter int N      = SAMPLE_N,
    parameter int TAPS   = FIR_TAPS,
    parameter int WARMUP = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N:0]                  in_sample,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [TAPS-1:0][N:0]        taps,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(TAPS+1)-1:0]   fill_count,
    output logic                        flush_done
);

    localparam int CW = $clog2(TAPS+1);

    tap_state_e     state;
    tap_state_e     state_next;
    logic [CW-1:0]  flush_cnt;
    logic           slot;
    logic           accept;
    logic           zero_shift;
    logic           flush_end;
    logic           last_fill;
    logic           emit;
    logic           flush_take;
    logic           flush_skip;
    logic           out_valid_next;

    always_comb begin
        slot       = !out_valid || out_ready;
        in_ready   = (state != FLUSH) && slot;
        accept     = in_valid && in_ready;
        last_fill  = (fill_count == CW'(TAPS-1));
        emit       = accept && ((state == RUN) || (WARMUP == 0) || last_fill);
        zero_shift = (state == FLUSH) && (flush_cnt != '0) && slot;
        flush_end  = (state == FLUSH) && (flush_cnt == '0) && out_valid && out_ready;
        // An accept in the flush cycle counts as a real sample, so the flush is honoured.
        flush_take = flush && (state != FLUSH) && ((fill_count != '0) || accept);
        flush_skip = flush && (state != FLUSH) && !flush_take;

        out_valid_next = out_valid;
        if (emit || zero_shift) begin
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end

        state_next = state;
        case (state)
            FILL: begin
                if (flush_take) begin
                    state_next = FLUSH;
                end else if (accept && ((WARMUP == 0) || last_fill)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush_take) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_end) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            fill_count <= '0;
            flush_cnt  <= '0;
            flush_done <= 1'b0;
        end else begin
            out_valid  <= out_valid_next;
            flush_done <= flush_end || flush_skip;
            if (flush_end) begin
                fill_count <= '0;
            end else if (accept && (fill_count != CW'(TAPS))) begin
                fill_count <= fill_count + CW'(1);
            end
            if (flush_take) begin
                flush_cnt <= CW'(TAPS-1);
            end else if (zero_shift) begin
                flush_cnt <= flush_cnt - CW'(1);
            end
        end
    end

    bc_tap_shift #(
        .W     (N+1),
        .DEPTH (TAPS)
    ) u_shift (
        .clock  (clock),
        .clear  (reset || flush_end),
        .enable (accept || zero_shift),
        .din    (zero_shift ? '0 : in_sample),
        .taps   (taps)
    );

endmodule

// File: tb/tb_bc_fir_tapline.sv
// tb/tb_bc_fir_tapline.sv - directed self-checking bench for bc_fir_tapline
module tb_bc_fir_tapline;

    logic              clock = 1'b0;
    logic              reset = 1'b1;

    logic [11:0]       in_sample = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [38:0][11:0] taps;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [5:0]        fill_count;
    logic              flush_done;

    logic [11:0]       in_sample0 = '0;
    logic              in_valid0 = 1'b0;
    logic              in_ready0;
    logic              flush0 = 1'b0;
    logic [38:0][11:0] taps0;
    logic              out_valid0;
    logic              out_ready0 = 1'b1;
    logic [5:0]        fill_count0;
    logic              flush_done0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    bc_fir_tapline #(.N(11), .TAPS(39), .WARMUP(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .taps       (taps),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_count (fill_count),
        .flush_done (flush_done)
    );

    bc_fir_tapline #(.N(11), .TAPS(39), .WARMUP(0)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .in_sample  (in_sample0),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .flush      (flush0),
        .taps       (taps0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready0),
        .fill_count (fill_count0),
        .flush_done (flush_done0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    initial begin
        logic [11:0] seq [79];
        int hits;
        int windows;
        int pulses;
        int last38;
        int last37;
        bit ready_bad;
        bit seen;

        // reset state
        repeat (2) @(negedge clock);
        check("rst_tap0", taps[0], 0);
        check("rst_tap38", taps[38], 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fill", fill_count, 0);
        check("rst_flush_done", flush_done, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // warm-up with samples 1..39
        for (int i = 1; i <= 39; i++) begin
            @(negedge clock);
            if (i == 39) begin
                check("warm_no_valid_38", out_valid, 0);
                check("warm_fill_38", fill_count, 38);
            end
            in_valid = 1'b1;
            in_sample = 12'(i);
        end
        @(negedge clock);
        check("warm_valid", out_valid, 1);
        check("warm_tap0", taps[0], 39);
        check("warm_tap38", taps[38], 1);
        check("warm_fill", fill_count, 39);
        in_sample = 12'd40;
        @(negedge clock);
        check("s40_tap0", taps[0], 40);
        check("s40_tap38", taps[38], 2);
        check("s40_fill_sat", fill_count, 39);

        // backpressure
        out_ready = 1'b0;
        in_sample = 12'd41;
        #1;
        check("bp_in_ready_low", in_ready, 0);
        repeat (5) begin
            @(negedge clock);
            check("bp_tap0_stable", taps[0], 40);
            check("bp_valid_held", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(negedge clock);
        check("bp_tap0", taps[0], 41);
        check("bp_tap1", taps[1], 40);
        check("bp_tap38", taps[38], 3);
        in_valid = 1'b0;
        @(negedge clock);
        check("consume_clears_valid", out_valid, 0);
        check("consume_tap0", taps[0], 41);

        // impulse
        for (int i = 0; i < 79; i++) seq[i] = '0;
        seq[39] = 12'd100;
        seq[78] = 12'd55;
        hits = 0;
        windows = 0;
        in_valid = 1'b1;
        for (int i = 0; i <= 79; i++) begin
            @(negedge clock);
            if (i > 0) begin
                if (out_valid) begin
                    windows++;
                    for (int k = 0; k < 39; k++) begin
                        if (taps[k] == 12'd100) hits++;
                    end
                end
                if (i - 1 == 39) check("imp_tap0", taps[0], 100);
                if (i - 1 == 77) check("imp_tap38", taps[38], 100);
            end
            if (i < 79) in_sample = seq[i];
        end
        check("imp_windows", windows, 79);
        check("imp_hits", hits, 39);

        // flush from RUN
        in_valid = 1'b0;
        flush = 1'b1;
        windows = 0;
        pulses = 0;
        seen = 0;
        ready_bad = 0;
        last38 = -1;
        last37 = -1;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clock);
            flush = 1'b0;
            if (flush_done) begin
                seen = 1;
                pulses++;
            end else if (out_valid) begin
                windows++;
                last38 = taps[38];
                last37 = taps[37];
                if (in_ready) ready_bad = 1;
            end
        end
        check("flush_done_seen", seen, 1);
        check("flush_windows", windows, 38);
        check("flush_in_ready_low", ready_bad, 0);
        check("flush_last_tap38", last38, 55);
        check("flush_last_tap37", last37, 0);
        check("flush_clr_tap38", taps[38], 0);
        check("flush_clr_tap0", taps[0], 0);
        check("flush_clr_fill", fill_count, 0);
        check("flush_clr_valid", out_valid, 0);
        @(negedge clock);
        if (flush_done) pulses++;
        check("flush_done_pulses", pulses, 1);
        check("post_flush_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_sample = 12'd9;
        @(negedge clock);
        in_valid = 1'b0;
        check("refill_silent", out_valid, 0);
        check("refill_fill", fill_count, 1);
        check("refill_tap0", taps[0], 9);

        // reset during flush after 10 zero shifts
        flush = 1'b1;
        windows = 0;
        for (int c = 0; c < 40 && windows < 10; c++) begin
            @(negedge clock);
            flush = 1'b0;
            if (out_valid) windows++;
        end
        check("mid_flush_windows", windows, 10);
        check("mid_flush_tap10", taps[10], 9);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_tap10", taps[10], 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_fill", fill_count, 0);
        check("mid_rst_flush_done", flush_done, 0);
        reset = 1'b0;

        // flush with an empty window is ignored but acknowledged
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("empty_flush_done", flush_done, 1);
        check("empty_flush_in_ready", in_ready, 1);
        @(negedge clock);
        check("empty_flush_done_once", flush_done, 0);

        // WARMUP=0 instance
        in_valid0 = 1'b1;
        in_sample0 = 12'd7;
        @(negedge clock);
        in_valid0 = 1'b0;
        check("nowarm_valid", out_valid0, 1);
        check("nowarm_tap0", taps0[0], 7);
        check("nowarm_tap1", taps0[1], 0);
        check("nowarm_tap38", taps0[38], 0);
        check("nowarm_fill", fill_count0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
